// File: rtl/pllcfg_pkg.sv
// rtl/pllcfg_pkg.sv - state encoding, register map and word type for the pll_cfg sequencer
package pllcfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_MODE,
        WR_FRAC,
        WR_C,
        WR_START,
        WAIT_LOCK,
        DONE
    } pllcfg_state_e;

    localparam logic [5:0] PLLCFG_A_MODE  = 6'd0;
    localparam logic [5:0] PLLCFG_A_START = 6'd2;
    localparam logic [5:0] PLLCFG_A_C     = 6'd5;
    localparam logic [5:0] PLLCFG_A_FRAC  = 6'd7;

    typedef logic [31:0] pllcfg_word_t;

endpackage

// File: rtl/pllcfg_req_filter.sv
// rtl/pllcfg_req_filter.sv - synchronises the async mode request and qualifies it once it has held steady
module pllcfg_req_filter #(
    parameter int MODE_W     = 2,
    parameter int STABLE_CYC = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [MODE_W-1:0] req_i,
    output logic [MODE_W-1:0] stable_o,
    output logic              valid_o
);

    localparam int CNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

    logic [MODE_W-1:0] sync1_q, sync2_q, cand_q;
    logic [CNT_W-1:0]  cnt_q;

    // cnt_q == k means the candidate has been seen on k+1 consecutive cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= req_i;
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign stable_o = cand_q;
    assign valid_o  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/pll_reconfig_seq.sv
// rtl/pll_reconfig_seq.sv - multi-mode pll_cfg reconfiguration sequencer; PLLCFG_LOCK_WAIT_EN adds the lock wait
module pll_reconfig_seq
    import pllcfg_pkg::*;
#(
    parameter int NUM_MODES    = 4,
    parameter int MODE_W       = $clog2(NUM_MODES),
    parameter int INIT_MODE    = 0,
    parameter int STABLE_CYC   = 8,
    parameter int GAP_CYC      = 3,
    parameter logic [32*NUM_MODES-1:0] MODE_FRAC = {NUM_MODES{32'hD8EC_0AC0}},
    parameter logic [32*NUM_MODES-1:0] MODE_C    = {NUM_MODES{32'h0}},
    parameter int LOCK_TIMEOUT = 1_000_000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [MODE_W-1:0] mode_req,
    output logic [MODE_W-1:0] mode_cur,
    output logic              busy,
    output logic              done,
    output logic              lock_err,
    input  logic              mgmt_waitrequest,
    output logic              mgmt_write,
    output logic [5:0]        mgmt_address,
    output logic [31:0]       mgmt_writedata,
    input  logic              locked
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    pllcfg_state_e     state_q, state_d, cmd_next;
    logic [MODE_W-1:0] target_q, target_d, mode_cur_q, mode_cur_d;
    logic              issued_q, issued_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [5:0]        addr_q, addr_d, cmd_addr;
    pllcfg_word_t      data_q, data_d, cmd_data;
    logic              write;
    logic [MODE_W-1:0] req_stable;
    logic              req_valid, req_in_range;
    logic [31:0]       tgt_idx;

    pllcfg_req_filter #(
        .MODE_W    (MODE_W),
        .STABLE_CYC(STABLE_CYC)
    ) u_req_filter (
        .clk_i   (clk_sys),
        .rst_ni  (reset),
        .req_i   (mode_req),
        .stable_o(req_stable),
        .valid_o (req_valid)
    );

    assign req_in_range = (32'(req_stable) < 32'(NUM_MODES));
    assign tgt_idx      = 32'(target_q);

`ifdef PLLCFG_LOCK_WAIT_EN
    localparam logic [31:0] TMO_LAST = 32'(LOCK_TIMEOUT - 1);

    logic        lock_s1_q, lock_s2_q;
    logic        seen_low_q, seen_low_d, lock_err_q, lock_err_d;
    logic [31:0] tmo_q, tmo_d;

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            lock_s1_q  <= 1'b0;
            lock_s2_q  <= 1'b0;
            seen_low_q <= 1'b0;
            lock_err_q <= 1'b0;
            tmo_q      <= '0;
        end else begin
            lock_s1_q  <= locked;
            lock_s2_q  <= lock_s1_q;
            seen_low_q <= seen_low_d;
            lock_err_q <= lock_err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign lock_err = lock_err_q;
`else
    logic unused_locked;
    assign unused_locked = locked;
    assign lock_err      = 1'b0;
`endif

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            target_q   <= MODE_W'(INIT_MODE);
            mode_cur_q <= MODE_W'(INIT_MODE);
            issued_q   <= 1'b0;
            gap_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            mode_cur_q <= mode_cur_d;
            issued_q   <= issued_d;
            gap_q      <= gap_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    // Register/data/successor for the write owned by the current state
    always_comb begin
        cmd_addr = PLLCFG_A_MODE;
        cmd_data = '0;
        cmd_next = WR_FRAC;
        case (state_q)
            WR_FRAC: begin
                cmd_addr = PLLCFG_A_FRAC;
                cmd_data = MODE_FRAC[tgt_idx*32 +: 32];
                cmd_next = WR_C;
            end
            WR_C: begin
                cmd_addr = PLLCFG_A_C;
                cmd_data = MODE_C[tgt_idx*32 +: 32];
                cmd_next = WR_START;
            end
            WR_START: begin
                cmd_addr = PLLCFG_A_START;
`ifdef PLLCFG_LOCK_WAIT_EN
                cmd_next = WAIT_LOCK;
`else
                cmd_next = DONE;
`endif
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        mode_cur_d = mode_cur_q;
        issued_d   = issued_q;
        gap_d      = gap_q;
        addr_d     = addr_q;
        data_d     = data_q;
        write      = 1'b0;
        done       = 1'b0;
`ifdef PLLCFG_LOCK_WAIT_EN
        seen_low_d = seen_low_q;
        lock_err_d = lock_err_q;
        tmo_d      = tmo_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_in_range && (req_stable != mode_cur_q)) begin
                    target_d = req_stable;
                    state_d  = WR_MODE;
                end
            end
            WR_MODE, WR_FRAC, WR_C, WR_START: begin
                // Both the strobe and the post-write gap advance only on ready cycles
                if (!mgmt_waitrequest) begin
                    if (!issued_q) begin
                        write    = 1'b1;
                        issued_d = 1'b1;
                        gap_d    = '0;
                        addr_d   = cmd_addr;
                        data_d   = cmd_data;
                    end else if (gap_q == GAP_LAST) begin
                        issued_d = 1'b0;
                        state_d  = cmd_next;
`ifdef PLLCFG_LOCK_WAIT_EN
                        seen_low_d = 1'b0;
                        tmo_d      = '0;
`endif
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            WAIT_LOCK: begin
`ifdef PLLCFG_LOCK_WAIT_EN
                if (seen_low_q && lock_s2_q) begin
                    lock_err_d = 1'b0;
                    state_d    = DONE;
                end else if (tmo_q == TMO_LAST) begin
                    lock_err_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (!lock_s2_q) begin
                    seen_low_d = 1'b1;
                end
`else
                state_d = DONE;
`endif
            end
            DONE: begin
                done       = 1'b1;
                mode_cur_d = target_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mgmt_write     = write;
    assign mgmt_address   = write ? cmd_addr : addr_q;
    assign mgmt_writedata = write ? cmd_data : data_q;
    assign mode_cur       = mode_cur_q;
    assign busy           = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// tb/tb_pll_reconfig_seq.sv - randomized self-checking bench for pll_reconfig_seq against a write-list model
module tb_pll_reconfig_seq;

    localparam int NM   = 4;
    localparam int MW   = 3;
    localparam int GAP  = 3;
    localparam int STAB = 8;
    localparam int LTO  = 300;
    localparam logic [127:0] FRAC_P = {32'h3C1A_77E5, 32'h1234_5678, 32'hA5A5_0F0F, 32'hD8EC_0AC0};
    localparam logic [127:0] C_P    = {32'h0000_0404, 32'h0002_0303, 32'h0001_0202, 32'h0000_0101};

    logic [31:0] frac_m [4] = '{32'hD8EC_0AC0, 32'hA5A5_0F0F, 32'h1234_5678, 32'h3C1A_77E5};
    logic [31:0] c_m    [4] = '{32'h0000_0101, 32'h0001_0202, 32'h0002_0303, 32'h0000_0404};

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [MW-1:0] mode_req = '0;
    logic          waitreq = 1'b0;
    logic          locked = 1'b1;
    logic [MW-1:0] mode_cur;
    logic          busy, done, lock_err, mgmt_write;
    logic [5:0]    mgmt_address;
    logic [31:0]   mgmt_writedata;

    typedef struct {logic [5:0] a; logic [31:0] d; int gap;} wr_t;
    typedef struct {logic [5:0] a; logic [31:0] d;} ex_t;
    wr_t log_q[$];
    ex_t exp_q[$];
    int  done_cnt = 0, viol = 0, ready_cnt = 0;
    int  n_checks = 0, n_fail = 0;
    bit  wr_rand = 0, wr_force = 0, lock_stuck = 0;

    pll_reconfig_seq #(
        .NUM_MODES(NM), .MODE_W(MW), .INIT_MODE(0), .STABLE_CYC(STAB), .GAP_CYC(GAP),
        .MODE_FRAC(FRAC_P), .MODE_C(C_P), .LOCK_TIMEOUT(LTO)
    ) dut (
        .clk_sys(clk), .reset(rst_n), .mode_req(mode_req), .mode_cur(mode_cur),
        .busy(busy), .done(done), .lock_err(lock_err),
        .mgmt_waitrequest(waitreq), .mgmt_write(mgmt_write),
        .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata), .locked(locked)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (wr_rand) waitreq = ($urandom_range(0, 3) == 0);
        else         waitreq = wr_force;
    end

    // Write log: each strobe with the number of ready cycles since the previous one
    always @(negedge clk) begin
        if (rst_n) begin
            if (mgmt_write) begin
                if (waitreq) viol++;
                log_q.push_back('{mgmt_address, mgmt_writedata, ready_cnt});
                ready_cnt = 0;
            end else if (!waitreq) begin
                ready_cnt++;
            end
            if (done) done_cnt++;
        end
    end

`ifdef PLLCFG_LOCK_WAIT_EN
    int lock_lo = 0;
    always @(negedge clk) begin
        if (rst_n && mgmt_write && mgmt_address == 6'd2) lock_lo = 6;
        locked = lock_stuck ? 1'b1 : (lock_lo == 0);
        if (lock_lo > 0) lock_lo--;
    end
`endif

    function automatic void push_seq(input int m);
        exp_q.push_back('{6'd0, 32'd0});
        exp_q.push_back('{6'd7, frac_m[m]});
        exp_q.push_back('{6'd5, c_m[m]});
        exp_q.push_back('{6'd2, 32'd0});
    endfunction

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_logs();
        log_q.delete();
        exp_q.delete();
        done_cnt = 0;
        viol = 0;
    endtask

    task automatic wait_done(input int n, input int budget, output bit timed_out);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            tick();
            k++;
        end
        timed_out = (done_cnt < n);
    endtask

    task automatic wait_log(input int n, input int budget, output bit timed_out);
        int k = 0;
        while (log_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        timed_out = (log_q.size() < n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mode_req = '0;
        repeat (3) tick();
        n_checks++;
        if ({mgmt_write, mgmt_address, mgmt_writedata, busy, done, lock_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wr=%b a=%0d d=%h busy=%b done=%b err=%b required all 0",
                     mgmt_write, mgmt_address, mgmt_writedata, busy, done, lock_err);
        end
        n_checks++;
        if (mode_cur !== 3'd0) begin n_fail++; $display("FAIL reset_mode_cur: got %0d required 0", mode_cur); end
        rst_n = 1'b1;
        clear_logs();
        repeat (1000) tick();
        n_checks++;
        if (log_q.size() != 0) begin n_fail++; $display("FAIL idle_strobes: got %0d required 0", log_q.size()); end
        n_checks++;
        if (mode_cur !== 3'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_state: got mode_cur=%0d busy=%b required 0 0", mode_cur, busy);
        end
    endtask

    task automatic test_basic();
        bit to;
        clear_logs();
        mode_req = 3'd2;
        push_seq(2);
        wait_log(2, 200, to);
        tick();
        n_checks++;
        if (to || mgmt_write !== 1'b0 || mgmt_address !== 6'd7 || mgmt_writedata !== frac_m[2] || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_hold: got to=%b wr=%b a=%0d d=%h busy=%b required 0 0 7 %h 1",
                     to, mgmt_write, mgmt_address, mgmt_writedata, busy, frac_m[2]);
        end
        wait_done(1, 200, to);
        tick();
        n_checks++;
        if (to || mode_cur !== 3'd2 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_done: got to=%b mode_cur=%0d busy=%b required 0 2 0", to, mode_cur, busy);
        end
        n_checks++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL basic_count: got %0d writes required %0d", log_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (log_q[i].a !== exp_q[i].a || log_q[i].d !== exp_q[i].d) begin
                n_fail++; $display("FAIL basic_write%0d: got a=%0d d=%h required a=%0d d=%h", i, log_q[i].a, log_q[i].d, exp_q[i].a, exp_q[i].d);
            end
            if (i % 4 != 0) begin
                n_checks++;
                if (log_q[i].gap != GAP) begin n_fail++; $display("FAIL basic_gap%0d: got %0d required %0d", i, log_q[i].gap, GAP); end
            end
        end
        n_checks++;
        if (mgmt_address !== 6'd2 || mgmt_writedata !== 32'd0 || done_cnt != 1) begin
            n_fail++; $display("FAIL basic_final: got a=%0d d=%h dones=%0d required 2 0 1", mgmt_address, mgmt_writedata, done_cnt);
        end
    endtask

    task automatic test_stall();
        bit to;
        clear_logs();
        mode_req = 3'd3;
        push_seq(3);
        wait_log(1, 200, to);
        wr_force = 1'b1;
        repeat (20) tick();
        n_checks++;
        if (to || log_q.size() != 1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL stall_hold: got to=%b writes=%0d busy=%b required 0 1 1", to, log_q.size(), busy);
        end
        wr_force = 1'b0;
        wait_done(1, 200, to);
        tick();
        n_checks++;
        if (to || mode_cur !== 3'd3 || viol != 0) begin
            n_fail++; $display("FAIL stall_done: got to=%b mode_cur=%0d viol=%0d required 0 3 0", to, mode_cur, viol);
        end
        n_checks++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL stall_count: got %0d writes required %0d", log_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (log_q[i].a !== exp_q[i].a || log_q[i].d !== exp_q[i].d) begin
                n_fail++; $display("FAIL stall_write%0d: got a=%0d d=%h required a=%0d d=%h", i, log_q[i].a, log_q[i].d, exp_q[i].a, exp_q[i].d);
            end
            if (i % 4 != 0) begin
                n_checks++;
                if (log_q[i].gap != GAP) begin n_fail++; $display("FAIL stall_gap%0d: got %0d required %0d", i, log_q[i].gap, GAP); end
            end
        end
    endtask

    task automatic test_glitch();
        clear_logs();
        mode_req = 3'd1;
        repeat (5) tick();
        mode_req = 3'd3;
        repeat (60) tick();
        n_checks++;
        if (log_q.size() != 0 || done_cnt != 0) begin
            n_fail++; $display("FAIL glitch: got writes=%0d dones=%0d required 0 0", log_q.size(), done_cnt);
        end
        mode_req = 3'd5;
        repeat (60) tick();
        n_checks++;
        if (log_q.size() != 0 || mode_cur !== 3'd3) begin
            n_fail++; $display("FAIL out_of_range: got writes=%0d mode_cur=%0d required 0 3", log_q.size(), mode_cur);
        end
        mode_req = 3'd3;
        repeat (20) tick();
    endtask

    task automatic test_mid_change();
        bit to;
        clear_logs();
        mode_req = 3'd1;
        push_seq(1);
        push_seq(0);
        wait_log(3, 200, to);
        mode_req = 3'd0;
        wait_done(2, 400, to);
        repeat (40) tick();
        n_checks++;
        if (to || mode_cur !== 3'd0 || done_cnt != 2) begin
            n_fail++; $display("FAIL mid_done: got to=%b mode_cur=%0d dones=%0d required 0 0 2", to, mode_cur, done_cnt);
        end
        n_checks++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL mid_count: got %0d writes required %0d", log_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (log_q[i].a !== exp_q[i].a || log_q[i].d !== exp_q[i].d) begin
                n_fail++; $display("FAIL mid_write%0d: got a=%0d d=%h required a=%0d d=%h", i, log_q[i].a, log_q[i].d, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_logs();
        mode_req = 3'd2;
        wait_log(2, 200, to);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (to || {mgmt_write, mgmt_address, mgmt_writedata, busy, done} !== '0 || mode_cur !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got to=%b wr=%b a=%0d d=%h busy=%b mode_cur=%0d required 0 0 0 0 0 0",
                     to, mgmt_write, mgmt_address, mgmt_writedata, busy, mode_cur);
        end
        clear_logs();
        repeat (5) tick();
        rst_n = 1'b1;
        push_seq(2);
        wait_done(1, 200, to);
        tick();
        n_checks++;
        if (to || mode_cur !== 3'd2) begin
            n_fail++; $display("FAIL post_reset_done: got to=%b mode_cur=%0d required 0 2", to, mode_cur);
        end
        n_checks++;
        if (log_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL post_reset_count: got %0d writes required %0d", log_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
            n_checks++;
            if (log_q[i].a !== exp_q[i].a || log_q[i].d !== exp_q[i].d) begin
                n_fail++; $display("FAIL post_reset_write%0d: got a=%0d d=%h required a=%0d d=%h", i, log_q[i].a, log_q[i].d, exp_q[i].a, exp_q[i].d);
            end
        end
    endtask

`ifdef PLLCFG_LOCK_WAIT_EN
    task automatic test_lock_timeout();
        bit to;
        clear_logs();
        lock_stuck = 1'b1;
        mode_req = 3'd0;
        wait_done(1, LTO + 200, to);
        tick();
        n_checks++;
        if (to || lock_err !== 1'b1 || mode_cur !== 3'd0) begin
            n_fail++; $display("FAIL lock_timeout: got to=%b err=%b mode_cur=%0d required 0 1 0", to, lock_err, mode_cur);
        end
        lock_stuck = 1'b0;
        clear_logs();
        mode_req = 3'd1;
        wait_done(1, LTO + 200, to);
        tick();
        n_checks++;
        if (to || lock_err !== 1'b0 || mode_cur !== 3'd1) begin
            n_fail++; $display("FAIL lock_recover: got to=%b err=%b mode_cur=%0d required 0 0 1", to, lock_err, mode_cur);
        end
    endtask
`endif

    task automatic test_random(input int start_mode);
        bit to;
        int cur_m = start_mode;
        int t, t2, nd;
        bit chg;
        wr_rand = 1'b1;
        for (int it = 0; it < 8; it++) begin
            clear_logs();
            do t = $urandom_range(0, NM - 1); while (t == cur_m);
            chg = $urandom_range(0, 1);
            mode_req = MW'(t);
            push_seq(t);
            nd = 1;
            t2 = t;
            if (chg) begin
                wait_log(1, 400, to);
                t2 = $urandom_range(0, NM - 1);
                mode_req = MW'(t2);
                if (t2 != t) begin push_seq(t2); nd = 2; end
            end
            cur_m = t2;
            wait_done(nd, 3000, to);
            repeat (30) tick();
            n_checks++;
            if (to || done_cnt != nd || mode_cur !== MW'(cur_m) || viol != 0) begin
                n_fail++; $display("FAIL rand%0d_done: got to=%b dones=%0d mode_cur=%0d viol=%0d required 0 %0d %0d 0",
                                   it, to, done_cnt, mode_cur, viol, nd, cur_m);
            end
            n_checks++;
            if (log_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL rand%0d_count: got %0d writes required %0d", it, log_q.size(), exp_q.size());
            end else foreach (exp_q[i]) begin
                n_checks++;
                if (log_q[i].a !== exp_q[i].a || log_q[i].d !== exp_q[i].d) begin
                    n_fail++; $display("FAIL rand%0d_write%0d: got a=%0d d=%h required a=%0d d=%h", it, i, log_q[i].a, log_q[i].d, exp_q[i].a, exp_q[i].d);
                end
                if (i % 4 != 0) begin
                    n_checks++;
                    if (log_q[i].gap != GAP) begin n_fail++; $display("FAIL rand%0d_gap%0d: got %0d required %0d", it, i, log_q[i].gap, GAP); end
                end
            end
        end
        wr_rand = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_glitch();
        test_mid_change();
        test_reset_mid();
`ifdef PLLCFG_LOCK_WAIT_EN
        test_lock_timeout();
        test_random(1);
`else
        test_random(2);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
